// File: rtl/vx_raster_sched.sv
// Raster pass sequencer: launches every raster unit, then round-robin merges their
// primitive streams into one registered output until all units have drained.
module vx_raster_sched #(
    parameter int NUM_UNITS = 2,
    parameter int PID_BITS  = 16,
    parameter int DIM_BITS  = 16,
    parameter int DATA_BITS = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_in,
    output logic                             busy_out,
    output logic                             done_out,
    output logic [31:0]                      prim_count,
    output logic [NUM_UNITS-1:0]             unit_start,
    input  logic [NUM_UNITS-1:0]             unit_busy,
    input  logic [NUM_UNITS-1:0]             unit_valid,
    input  logic [NUM_UNITS*PID_BITS-1:0]    unit_pid,
    input  logic [NUM_UNITS*DIM_BITS-1:0]    unit_xloc,
    input  logic [NUM_UNITS*DIM_BITS-1:0]    unit_yloc,
    input  logic [NUM_UNITS*9*DATA_BITS-1:0] unit_edges,
    output logic [NUM_UNITS-1:0]             unit_ready,
    output logic                             valid_out,
    output logic [PID_BITS-1:0]              pid_out,
    output logic [DIM_BITS-1:0]              xloc_out,
    output logic [DIM_BITS-1:0]              yloc_out,
    output logic [9*DATA_BITS-1:0]           edges_out,
    input  logic                             ready_out
);
    localparam int LG_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int EDGE_W = 9 * DATA_BITS;
    localparam logic [LG_W-1:0] LAST_INIT = LG_W'(NUM_UNITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t               state_r;
    logic [LG_W-1:0]      last_grant_r;
    logic [NUM_UNITS-1:0] unit_start_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 valid_r;
    logic [31:0]          prim_count_r;
    logic [PID_BITS-1:0]  pid_r;
    logic [DIM_BITS-1:0]  xloc_r;
    logic [DIM_BITS-1:0]  yloc_r;
    logic [EDGE_W-1:0]    edges_r;

    logic [LG_W-1:0]      grant_idx_s;
    logic                 grant_any_s;
    logic                 accept_s;
    logic                 xfer_s;
    logic                 fire_s;
    logic                 run_done_s;
    logic                 start_acc_s;
    logic [NUM_UNITS-1:0] unit_ready_s;
    logic [PID_BITS-1:0]  pid_s;
    logic [DIM_BITS-1:0]  xloc_s;
    logic [DIM_BITS-1:0]  yloc_s;
    logic [EDGE_W-1:0]    edges_s;

    // Round-robin pick: lowest requester above last_grant wins, else lowest requester overall.
    always_comb begin
        grant_idx_s = last_grant_r;
        grant_any_s = 1'b0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            grant_idx_s = (unit_valid[i] && (LG_W'(i) <= last_grant_r)) ? LG_W'(i) : grant_idx_s;
            grant_any_s = grant_any_s | unit_valid[i];
        end
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            grant_idx_s = (unit_valid[i] && (LG_W'(i) > last_grant_r)) ? LG_W'(i) : grant_idx_s;
        end
    end

    // Steer the granted unit's ready and payload; nothing is accepted while reset is held.
    always_comb begin
        accept_s     = reset && grant_any_s && (!valid_r || ready_out);
        unit_ready_s = {NUM_UNITS{1'b0}};
        pid_s        = {PID_BITS{1'b0}};
        xloc_s       = {DIM_BITS{1'b0}};
        yloc_s       = {DIM_BITS{1'b0}};
        edges_s      = {EDGE_W{1'b0}};
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant_idx_s == LG_W'(i)) begin
                unit_ready_s[i] = accept_s;
                pid_s           = unit_pid[i*PID_BITS +: PID_BITS];
                xloc_s          = unit_xloc[i*DIM_BITS +: DIM_BITS];
                yloc_s          = unit_yloc[i*DIM_BITS +: DIM_BITS];
                edges_s         = unit_edges[i*EDGE_W +: EDGE_W];
            end else begin
                unit_ready_s[i] = 1'b0;
            end
        end
    end

    assign xfer_s      = |(unit_valid & unit_ready_s);
    assign fire_s      = valid_r && ready_out;
    assign run_done_s  = (unit_busy == {NUM_UNITS{1'b0}}) && (unit_valid == {NUM_UNITS{1'b0}}) && !valid_r;
    assign start_acc_s = (state_r == IDLE) && start_in;

    // Pass sequencer; start is only honoured from IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            unit_start_r <= {NUM_UNITS{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            unit_start_r <= {NUM_UNITS{1'b0}};
            done_r       <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_in) begin
                        state_r      <= LAUNCH;
                        unit_start_r <= {NUM_UNITS{1'b1}};
                        busy_r       <= 1'b1;
                    end
                end
                LAUNCH: state_r <= SETTLE;
                SETTLE: state_r <= RUN;
                RUN: begin
                    if (run_done_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Arbiter pointer moves only when a unit actually hands over a primitive.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_r <= LAST_INIT;
        end else if (xfer_s) begin
            last_grant_r <= grant_idx_s;
        end
    end

    // Output occupancy: simultaneous fire and load keeps the register full.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_r <= 1'b0;
        end else if (xfer_s) begin
            valid_r <= 1'b1;
        end else if (fire_s) begin
            valid_r <= 1'b0;
        end
    end

    // Payload captures only on a transfer, so a stalled output holds steady.
    always_ff @(posedge clk) begin
        if (xfer_s) begin
            pid_r   <= pid_s;
            xloc_r  <= xloc_s;
            yloc_r  <= yloc_s;
            edges_r <= edges_s;
        end
    end

    // Transfer counter; an accepted start clears it and swallows a coincident increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prim_count_r <= 32'd0;
        end else if (start_acc_s) begin
            prim_count_r <= 32'd0;
        end else if (fire_s) begin
            prim_count_r <= prim_count_r + 32'd1;
        end
    end

    assign busy_out   = busy_r;
    assign done_out   = done_r;
    assign prim_count = prim_count_r;
    assign unit_start = unit_start_r;
    assign unit_ready = unit_ready_s;
    assign valid_out  = valid_r;
    assign pid_out    = pid_r;
    assign xloc_out   = xloc_r;
    assign yloc_out   = yloc_r;
    assign edges_out  = edges_r;

endmodule
